rgb_duty_ramp: RTL and testbench
================================

RGB_DUTY_RAMP -- requirements
Module: rgb_duty_ramp

Interface
REQ-001 The block SHALL have parameter CTR_LEN, default 8, giving the duty width and the PWM period counter width (period = 2^CTR_LEN cycles).
REQ-002 The block SHALL have parameter RAMP_DIV, default 4, giving the number of PWM periods between ramp steps (legal range 1..256).
REQ-003 Port clk SHALL be an input of width 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input of width 1: new target triple is present.
REQ-006 Port in_ready SHALL be an output of width 1: block can accept a target triple.
REQ-007 Ports in_red, in_green and in_blue SHALL each be inputs of width CTR_LEN: target duty per channel.
REQ-008 Ports red_compare, green_compare and blue_compare SHALL each be outputs of width CTR_LEN: registered duty values that feed the compare input of the downstream per-channel PWM stage.
REQ-009 Port busy SHALL be an output of width 1: high while any compare differs from its active target.

Function
REQ-010 The block SHALL run a free-running period counter per_ctr (CTR_LEN bits) that increments every cycle and wraps from all-ones to 0.
REQ-011 period_end SHALL be asserted in the cycle where per_ctr is all-ones, aligning with the downstream PWM counter wrap when both leave reset on the same edge.
REQ-012 A divider div_ctr SHALL count period_end events 0..RAMP_DIV-1 and wrap; step_tick SHALL be period_end AND div_ctr == RAMP_DIV-1.
REQ-013 Handshake: a transfer SHALL occur when in_valid and in_ready are both high on a rising edge; in_ready SHALL equal NOT pending_valid (combinational).
REQ-014 On transfer, in_red, in_green and in_blue SHALL be captured into a pending register and pending_valid SHALL be set; the source may change inputs from the next cycle onward.
REQ-015 At period_end with pending_valid set, the pending triple SHALL be copied into the active targets and pending_valid SHALL be cleared, so in_ready rises in the following cycle.
REQ-016 A transfer in the same cycle as period_end (pending empty) SHALL load pending only; the copy to the active targets SHALL occur at the next period_end.
REQ-017 On step_tick, each compare SHALL move by exactly 1 toward its active target (increment if below, decrement if above, hold if equal).
REQ-018 Compare outputs SHALL change only on step_tick edges, therefore only at a PWM period boundary (glitch-free duty update).
REQ-019 When period_end carries both a target copy and a step_tick, the step SHALL use the old targets; the new targets SHALL take effect from the next step_tick.
REQ-020 Compare arithmetic SHALL never wrap: values move only toward targets within 0..2^CTR_LEN-1, and both endpoints SHALL be reachable and held.
REQ-021 The FSM SHALL have two states. IDLE: all compares equal their targets, busy=0. RAMP: busy=1.
REQ-022 The FSM SHALL move IDLE->RAMP on the edge where a target copy makes any compare differ from its new target.
REQ-023 The FSM SHALL move RAMP->IDLE on the edge where a step_tick makes all three compares equal their targets.
REQ-024 A target copied while in RAMP SHALL retarget immediately; the direction of each channel may reverse, and the FSM SHALL remain in RAMP unless all three compares already equal the new targets, in which case it SHALL move to IDLE.
REQ-025 busy SHALL be registered and equal (state == RAMP).

Reset
REQ-026 While rst is high on an edge, the block SHALL clear per_ctr, div_ctr, all compares, all active and pending targets and pending_valid, and SHALL set the state to IDLE and busy to 0; outputs are therefore compare=0, busy=0, in_ready=1 after that edge.
REQ-027 Handshakes presented while rst is high SHALL be ignored; reset mid-ramp SHALL abandon the ramp and drop the pending target.

Verification (CTR_LEN=8)
REQ-028 Rise (RAMP_DIV=1): reset, then transfer (10,0,255) -> in_ready=0 until the first period_end, then 1. red_compare SHALL reach 10 after 10 further period_ends, green_compare SHALL stay 0, blue_compare SHALL reach 255 after 255 period_ends, and busy SHALL fall on that edge.
REQ-029 Fall (RAMP_DIV=4): from compares at 255, target (250,250,250) -> a decrement every 1024 cycles, 5 steps total, then busy=0.
REQ-030 Back-pressure: second in_valid held while pending -> not accepted while in_ready=0; accepted on the first edge where in_ready=1 after the next period_end.
REQ-031 Reversal: red ramping 0->200 and currently at 50, new target 20 -> red SHALL decrement from the first step_tick after the copy and settle at 20.
REQ-032 Reset mid-ramp: rst pulsed with red=120 -> red_compare=0, busy=0, in_ready=1 on the next cycle, and no further steps occur.
REQ-033 No-op: target equal to the current compares -> busy SHALL stay 0 and no compare SHALL change.

Source files
------------

// File: rtl/rgb_duty_ramp.sv
// RGB duty ramp: accepts target duty triples and walks three PWM compare values
// toward them one LSB per ramp step, changing compares only at PWM period boundaries.
module rgb_duty_ramp #(
    parameter int CTR_LEN  = 8,
    parameter int RAMP_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTR_LEN-1:0] in_red,
    input  logic [CTR_LEN-1:0] in_green,
    input  logic [CTR_LEN-1:0] in_blue,
    output logic [CTR_LEN-1:0] red_compare,
    output logic [CTR_LEN-1:0] green_compare,
    output logic [CTR_LEN-1:0] blue_compare,
    output logic               busy
);

    localparam int                 DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
    localparam logic [CTR_LEN-1:0] CTR_ONE  = CTR_LEN'(1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RAMP = 1'b1;

    // One LSB toward the target; never wraps because it stops on equality.
    function automatic logic [CTR_LEN-1:0] step_toward(input logic [CTR_LEN-1:0] cur,
                                                       input logic [CTR_LEN-1:0] tgt);
        logic [CTR_LEN-1:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + CTR_ONE;
        end else if (cur > tgt) begin
            nxt = cur - CTR_ONE;
        end
        return nxt;
    endfunction

    logic [CTR_LEN-1:0] per_ctr;
    logic [DIV_W-1:0]   div_ctr;
    logic               period_end;
    logic               step_tick;
    logic               transfer;
    logic               copy;

    logic               pending_valid;
    logic [CTR_LEN-1:0] pend_red, pend_green, pend_blue;
    logic [CTR_LEN-1:0] tgt_red, tgt_green, tgt_blue;
    logic [CTR_LEN-1:0] tgt_red_next, tgt_green_next, tgt_blue_next;
    logic [CTR_LEN-1:0] red_next, green_next, blue_next;
    logic               differ;
    logic [0:0]         state;

    assign period_end = &per_ctr;
    assign step_tick  = period_end && (div_ctr == DIV_LAST);
    assign in_ready   = ~pending_valid;
    assign transfer   = in_valid && in_ready;
    assign copy       = period_end && pending_valid;
    assign busy       = (state == RAMP);

    // Steps use the targets active before this edge; a coincident copy only
    // affects the comparison that decides the next FSM state.
    always_comb begin
        red_next       = red_compare;
        green_next     = green_compare;
        blue_next      = blue_compare;
        tgt_red_next   = tgt_red;
        tgt_green_next = tgt_green;
        tgt_blue_next  = tgt_blue;
        if (step_tick) begin
            red_next   = step_toward(red_compare, tgt_red);
            green_next = step_toward(green_compare, tgt_green);
            blue_next  = step_toward(blue_compare, tgt_blue);
        end
        if (copy) begin
            tgt_red_next   = pend_red;
            tgt_green_next = pend_green;
            tgt_blue_next  = pend_blue;
        end
        differ = (red_next != tgt_red_next) || (green_next != tgt_green_next) ||
                 (blue_next != tgt_blue_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_ctr       <= '0;
            div_ctr       <= '0;
            pending_valid <= 1'b0;
            pend_red      <= '0;
            pend_green    <= '0;
            pend_blue     <= '0;
            tgt_red       <= '0;
            tgt_green     <= '0;
            tgt_blue      <= '0;
            red_compare   <= '0;
            green_compare <= '0;
            blue_compare  <= '0;
            state         <= IDLE;
        end else begin
            per_ctr <= per_ctr + CTR_ONE;
            if (period_end) begin
                div_ctr <= (div_ctr == DIV_LAST) ? '0 : div_ctr + DIV_ONE;
            end

            // transfer and copy are mutually exclusive: one needs pending empty, the other full
            if (transfer) begin
                pend_red      <= in_red;
                pend_green    <= in_green;
                pend_blue     <= in_blue;
                pending_valid <= 1'b1;
            end else if (copy) begin
                pending_valid <= 1'b0;
            end

            tgt_red       <= tgt_red_next;
            tgt_green     <= tgt_green_next;
            tgt_blue      <= tgt_blue_next;
            red_compare   <= red_next;
            green_compare <= green_next;
            blue_compare  <= blue_next;

            if (copy || step_tick) begin
                state <= differ ? RAMP : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_rgb_duty_ramp.sv
// Bench for rgb_duty_ramp: two instances (RAMP_DIV=1 and RAMP_DIV=4) checked against
// a cycle-count based reference model plus fixed expectations.
module tb_rgb_duty_ramp;

    localparam int W = 8;
    localparam int P = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld [2];
    logic [W-1:0] din [2][3];
    logic rdy0, rdy1, bsy0, bsy1;
    logic [W-1:0] r0, g0, b0, r1, g1, b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rgb_duty_ramp #(.CTR_LEN(W), .RAMP_DIV(1)) dut_div1 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy0),
        .in_red(din[0][0]), .in_green(din[0][1]), .in_blue(din[0][2]),
        .red_compare(r0), .green_compare(g0), .blue_compare(b0), .busy(bsy0)
    );

    rgb_duty_ramp #(.CTR_LEN(W), .RAMP_DIV(4)) dut_div4 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy1),
        .in_red(din[1][0]), .in_green(din[1][1]), .in_blue(din[1][2]),
        .red_compare(r1), .green_compare(g1), .blue_compare(b1), .busy(bsy1)
    );

    function automatic logic [W-1:0] dcmp(input int i, input int c);
        if (i == 0) return (c == 0) ? r0 : (c == 1) ? g0 : b0;
        return (c == 0) ? r1 : (c == 1) ? g1 : b1;
    endfunction
    function automatic logic drdy(input int i);
        return (i == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic dbsy(input int i);
        return (i == 0) ? bsy0 : bsy1;
    endfunction

    // Reference model: timing derived from the number of edges since reset.
    int           m_cyc  [2];
    logic         m_pv   [2];
    logic [W-1:0] m_cmp  [2][3];
    logic [W-1:0] m_tgt  [2][3];
    logic [W-1:0] m_pend [2][3];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction
    function automatic logic [W-1:0] toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        int d;
        d = int'(tgt) - int'(cur);
        return W'(int'(cur) + ((d > 0) ? 1 : 0) - ((d < 0) ? 1 : 0));
    endfunction
    function automatic logic m_busy(input int i);
        return (m_cmp[i][0] != m_tgt[i][0]) || (m_cmp[i][1] != m_tgt[i][1]) ||
               (m_cmp[i][2] != m_tgt[i][2]);
    endfunction

    always @(posedge clk) begin : model
        bit pe, st;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cyc[i] <= 0;
                m_pv[i]  <= 1'b0;
                for (int c = 0; c < 3; c++) begin
                    m_cmp[i][c]  <= '0;
                    m_tgt[i][c]  <= '0;
                    m_pend[i][c] <= '0;
                end
            end else begin
                pe = (m_cyc[i] % P) == P - 1;
                st = pe && (((m_cyc[i] / P) % div_of(i)) == div_of(i) - 1);
                for (int c = 0; c < 3; c++) begin
                    if (st) m_cmp[i][c] <= toward(m_cmp[i][c], m_tgt[i][c]);
                    if (pe && m_pv[i]) m_tgt[i][c] <= m_pend[i][c];
                    if (vld[i] && !m_pv[i]) m_pend[i][c] <= din[i][c];
                end
                if (pe && m_pv[i]) m_pv[i] <= 1'b0;
                else if (vld[i] && !m_pv[i]) m_pv[i] <= 1'b1;
                m_cyc[i] <= m_cyc[i] + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Holds in_valid until accepted (bounded); returns at the negedge after the transfer edge.
    task automatic send(input int i, input logic [W-1:0] r, input logic [W-1:0] g,
                        input logic [W-1:0] b, output bit ok);
        int k;
        k = 0;
        din[i][0] = r;
        din[i][1] = g;
        din[i][2] = b;
        vld[i]    = 1'b1;
        while (drdy(i) !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        ok = (drdy(i) === 1'b1);
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vld[0] = 1'b1;
        vld[1] = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 3; c++) din[i][c] = W'($urandom_range(1, 255));
        tick(3);
        rst = 1'b0;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (dcmp(i, c) !== 8'd0) begin
                    n_fail++;
                    $display("FAIL reset_compare dut%0d ch%0d: got %0d expected 0", i, c, dcmp(i, c));
                end
            end
            n_tests++;
            if (dbsy(i) !== 1'b0 || drdy(i) !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d: busy=%b ready=%b expected busy=0 ready=1", i, dbsy(i), drdy(i));
            end
        end
        tick(300);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (drdy(i) !== 1'b1 || dbsy(i) !== 1'b0 || dcmp(i, 0) !== 8'd0 || dcmp(i, 2) !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_handshake_ignored dut%0d: ready=%b busy=%b red=%0d expected 1 0 0",
                         i, drdy(i), dbsy(i), dcmp(i, 0));
            end
        end
    endtask

    task automatic test_rise;
        bit ok;
        int n;
        logic pb;
        send(0, 8'd10, 8'd0, 8'd255, ok);
        n_tests++;
        if (!ok || rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_accept: accepted=%b ready=%b expected 1 0", ok, rdy0);
        end
        n = 0;
        while (rdy0 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        n_tests++;
        if (n != 255) begin
            n_fail++;
            $display("FAIL rise_ready_latency: got %0d cycles expected 255", n);
        end
        n_tests++;
        if (bsy0 !== 1'b1 || r0 !== 8'd0) begin
            n_fail++;
            $display("FAIL rise_after_copy: busy=%b red=%0d expected busy=1 red=0", bsy0, r0);
        end
        n = 0;
        while (r0 !== 8'd10 && n < 4000) begin @(negedge clk); n++; end
        n_tests++;
        if (n != 2560) begin
            n_fail++;
            $display("FAIL rise_red_time: got %0d cycles expected 2560", n);
        end
        n_tests++;
        if (g0 !== 8'd0) begin
            n_fail++;
            $display("FAIL rise_green_hold: got %0d expected 0", g0);
        end
        pb = bsy0;
        while (b0 !== 8'd255 && n < 70000) begin pb = bsy0; @(negedge clk); n++; end
        n_tests++;
        if (n != 65280) begin
            n_fail++;
            $display("FAIL rise_blue_time: got %0d cycles expected 65280", n);
        end
        n_tests++;
        if (pb !== 1'b1 || bsy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_busy_fall: before=%b after=%b expected 1 0", pb, bsy0);
        end
        tick(600);
        n_tests++;
        if (r0 !== 8'd10 || g0 !== 8'd0 || b0 !== 8'd255 || bsy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_endpoint_hold: got %0d,%0d,%0d busy=%b expected 10,0,255 busy=0", r0, g0, b0, bsy0);
        end
    endtask

    task automatic test_ramp_div4;
        bit ok;
        int n, t, last, changes, bad_dir, bad_int;
        logic [W-1:0] prev;
        send(1, 8'd5, 8'd5, 8'd5, ok);
        n = 0;
        while ((r1 !== 8'd5 || g1 !== 8'd5 || b1 !== 8'd5 || bsy1 !== 1'b0) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!ok || n != 5119) begin
            n_fail++;
            $display("FAIL div4_rise_time: accepted=%b got %0d cycles expected 5119", ok, n);
        end
        send(1, 8'd0, 8'd0, 8'd0, ok);
        prev = r1; t = 0; last = -1; changes = 0; bad_dir = 0; bad_int = 0;
        while ((r1 !== 8'd0 || bsy1 !== 1'b0) && t < 7000) begin
            @(negedge clk);
            t++;
            if (r1 !== prev) begin
                changes++;
                if (int'(r1) != int'(prev) - 1) bad_dir++;
                if (last >= 0 && t - last != 1024) bad_int++;
                last = t;
                prev = r1;
            end
        end
        n_tests++;
        if (!ok || changes != 5) begin
            n_fail++;
            $display("FAIL div4_fall_steps: accepted=%b got %0d steps expected 5", ok, changes);
        end
        n_tests++;
        if (bad_dir != 0 || bad_int != 0) begin
            n_fail++;
            $display("FAIL div4_fall_shape: got %0d bad directions %0d bad intervals expected 0 0", bad_dir, bad_int);
        end
        n_tests++;
        if (g1 !== 8'd0 || b1 !== 8'd0 || bsy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL div4_fall_end: got g=%0d b=%0d busy=%b expected 0 0 0", g1, b1, bsy1);
        end
        tick(1100);
        n_tests++;
        if (r1 !== 8'd0 || bsy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL div4_zero_hold: got red=%0d busy=%b expected 0 0", r1, bsy1);
        end
    endtask

    task automatic test_noop;
        bit ok, ok2;
        int bad, n;
        logic [W-1:0] t [3];
        send(1, 8'd0, 8'd0, 8'd0, ok);
        bad = 0;
        for (int k = 0; k < 1300; k++) begin
            @(negedge clk);
            if (bsy1 !== 1'b0 || r1 !== 8'd0 || g1 !== 8'd0 || b1 !== 8'd0) bad++;
        end
        n_tests++;
        if (!ok || bad != 0) begin
            n_fail++;
            $display("FAIL noop_zero: accepted=%b got %0d disturbed cycles expected 0", ok, bad);
        end
        for (int c = 0; c < 3; c++) t[c] = W'($urandom_range(1, 3));
        send(1, t[0], t[1], t[2], ok);
        n = 0;
        while ((bsy1 !== 1'b0 || rdy1 !== 1'b1 || r1 !== t[0]) && n < 6000) begin @(negedge clk); n++; end
        n_tests++;
        if (r1 !== t[0] || g1 !== t[1] || b1 !== t[2]) begin
            n_fail++;
            $display("FAIL noop_setup: got %0d,%0d,%0d expected %0d,%0d,%0d", r1, g1, b1, t[0], t[1], t[2]);
        end
        send(1, t[0], t[1], t[2], ok2);
        bad = 0;
        for (int k = 0; k < 1300; k++) begin
            @(negedge clk);
            if (bsy1 !== 1'b0 || r1 !== t[0] || g1 !== t[1] || b1 !== t[2]) bad++;
        end
        n_tests++;
        if (!ok || !ok2 || bad != 0) begin
            n_fail++;
            $display("FAIL noop_equal: accepted=%b%b got %0d disturbed cycles expected 0", ok, ok2, bad);
        end
    endtask

    task automatic test_random;
        bit ok;
        int bad, n;
        for (int it = 0; it < 10; it++) begin
            send(1, W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), ok);
            bad = 0;
            for (int k = 0; k < int'($urandom_range(50, 600)); k++) begin
                @(negedge clk);
                for (int c = 0; c < 3; c++) if (dcmp(1, c) !== m_cmp[1][c]) bad++;
                if (bsy1 !== m_busy(1) || rdy1 !== !m_pv[1]) bad++;
            end
            n_tests++;
            if (!ok || bad != 0) begin
                n_fail++;
                $display("FAIL random_iter%0d: accepted=%b got %0d model disagreements expected 0", it, ok, bad);
            end
        end
        n = 0;
        while ((bsy1 !== 1'b0 || rdy1 !== 1'b1) && n < 12000) begin @(negedge clk); n++; end
        n_tests++;
        if (r1 !== m_cmp[1][0] || g1 !== m_cmp[1][1] || b1 !== m_cmp[1][2] || bsy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL random_settle: got %0d,%0d,%0d busy=%b expected %0d,%0d,%0d busy=0",
                     r1, g1, b1, bsy1, m_cmp[1][0], m_cmp[1][1], m_cmp[1][2]);
        end
    endtask

    task automatic test_fall;
        bit ok;
        int t, last, changes, bad;
        logic [W-1:0] prev;
        send(0, 8'd10, 8'd0, 8'd250, ok);
        prev = b0; t = 0; last = -1; changes = 0; bad = 0;
        while ((b0 !== 8'd250 || bsy0 !== 1'b0) && t < 2000) begin
            @(negedge clk);
            t++;
            if (b0 !== prev) begin
                changes++;
                if (int'(b0) != int'(prev) - 1) bad++;
                if (last >= 0 && t - last != 256) bad++;
                last = t;
                prev = b0;
            end
        end
        n_tests++;
        if (!ok || changes != 5 || bad != 0) begin
            n_fail++;
            $display("FAIL fall_steps: accepted=%b got %0d steps %0d irregular expected 5 0", ok, changes, bad);
        end
        n_tests++;
        if (r0 !== 8'd10 || g0 !== 8'd0 || bsy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_others: got r=%0d g=%0d busy=%b expected 10 0 0", r0, g0, bsy0);
        end
    endtask

    task automatic test_back_to_back;
        int n, bad;
        n_tests++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_idle: got %b expected 1", rdy0);
        end
        din[0][0] = 8'd13; din[0][1] = 8'd3; din[0][2] = 8'd245;
        vld[0] = 1'b1;
        @(negedge clk);
        din[0][0] = 8'd8; din[0][1] = 8'd0; din[0][2] = 8'd252;
        n_tests++;
        if (rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_low: got %b expected 0", rdy0);
        end
        n = 0; bad = 0;
        while (rdy0 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            for (int c = 0; c < 3; c++) if (dcmp(0, c) !== m_cmp[0][c]) bad++;
        end
        n_tests++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_return: got %b after %0d cycles expected 1", rdy0, n);
        end
        @(negedge clk);
        vld[0] = 1'b0;
        n_tests++;
        if (rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_accept: ready=%b expected 0", rdy0);
        end
        n = 0;
        while ((bsy0 !== 1'b0 || rdy0 !== 1'b1 || r0 !== 8'd8) && n < 4000) begin
            @(negedge clk);
            n++;
            for (int c = 0; c < 3; c++) if (dcmp(0, c) !== m_cmp[0][c]) bad++;
            if (bsy0 !== m_busy(0)) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_model: got %0d disagreements expected 0", bad);
        end
        n_tests++;
        if (r0 !== 8'd8 || g0 !== 8'd0 || b0 !== 8'd252 || bsy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_final: got %0d,%0d,%0d busy=%b expected 8,0,252 busy=0", r0, g0, b0, bsy0);
        end
    endtask

    task automatic test_reversal;
        bit ok, ok2;
        int n, t, changes, bad;
        logic [W-1:0] prev, first;
        pulse_reset();
        send(0, 8'd200, 8'd0, 8'd0, ok);
        n = 0;
        while (r0 !== 8'd12 && n < 4000) begin @(negedge clk); n++; end
        n_tests++;
        if (!ok || r0 !== 8'd12) begin
            n_fail++;
            $display("FAIL rev_climb: accepted=%b red=%0d expected 12", ok, r0);
        end
        send(0, 8'd5, 8'd0, 8'd0, ok2);
        prev = 8'd12; first = 8'd0; t = 0; changes = 0; bad = 0;
        while ((r0 !== 8'd5 || bsy0 !== 1'b0) && t < 4000) begin
            @(negedge clk);
            t++;
            if (r0 !== prev) begin
                changes++;
                if (changes == 1) first = r0;
                else if (int'(r0) != int'(prev) - 1) bad++;
                prev = r0;
            end
        end
        n_tests++;
        if (!ok2 || first !== 8'd13) begin
            n_fail++;
            $display("FAIL rev_copy_step: accepted=%b got %0d expected 13", ok2, first);
        end
        n_tests++;
        if (changes != 9 || bad != 0 || r0 !== 8'd5 || bsy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_descent: got %0d steps %0d bad red=%0d busy=%b expected 9 0 5 0",
                     changes, bad, r0, bsy0);
        end
    endtask

    task automatic test_reset_mid_ramp;
        bit ok, ok2;
        int n, bad;
        pulse_reset();
        send(0, 8'd120, 8'd0, 8'd0, ok);
        n = 0;
        while (r0 !== 8'd8 && n < 3000) begin @(negedge clk); n++; end
        send(0, 8'd99, 8'd0, 8'd0, ok2);
        rst = 1'b1;
        vld[0] = 1'b1;
        for (int c = 0; c < 3; c++) din[0][c] = 8'd50;
        @(negedge clk);
        rst = 1'b0;
        vld[0] = 1'b0;
        n_tests++;
        if (!ok || !ok2 || r0 !== 8'd0 || bsy0 !== 1'b0 || rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_state: accepted=%b%b red=%0d busy=%b ready=%b expected 11 0 0 1",
                     ok, ok2, r0, bsy0, rdy0);
        end
        bad = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (r0 !== 8'd0 || g0 !== 8'd0 || b0 !== 8'd0 || bsy0 !== 1'b0 || rdy0 !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 3; c++) din[i][c] = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        pulse_reset();
        fork
            test_rise();
            begin
                test_ramp_div4();
                test_noop();
                test_random();
            end
        join
        test_fall();
        test_back_to_back();
        test_reversal();
        test_reset_mid_ramp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
